cache_port_arbiter: RTL

- Shares the single CPU-side port of the cache (C1/A1/D1 transaction level) between two requesters: port 0 for instruction fetch, port 1 for data.
- Sits between the requesters and the cache's bus-1 adapter.
- Round-robin grant, one outstanding cache transaction at a time.
- Per-transaction timeout returns an error response instead of hanging.

---
 rtl/cache_port_arbiter_pkg.sv | 33 +++
 rtl/cache_port_arbiter_if.sv | 53 +++++
 rtl/cache_port_arbiter_rr_arbiter2.sv | 16 +
 rtl/cache_port_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the cache CPU-port arbiter: C1 command codes, FSM states
// and the read-data width mask applied to cache responses.
package cache_arb_pkg;

  typedef enum logic [2:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_WRITE32         = 3'd7
  } c1_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } arb_state_t;

  // Narrow reads return zero-extended data; writes and invalidates return zero.
  function automatic logic [31:0] mask_rdata(input c1_cmd_t cmd, input logic [31:0] data);
    case (cmd)
      C1_READ8:  mask_rdata = {24'h0, data[7:0]};
      C1_READ16: mask_rdata = {16'h0, data[15:0]};
      C1_READ32: mask_rdata = data;
      default:   mask_rdata = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the cache bus-1 adapter.
// Handshake: pN_valid is held until pN_ready, which pulses for one cycle in the
// accept cycle only while the arbiter is idle; pN_resp, c_valid and c_resp are
// single-cycle pulses with no backpressure, and their data is valid only with the pulse.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
);
  logic              p0_valid;
  logic [2:0]        p0_cmd;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ready;
  logic              p0_resp;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_valid;
  logic [2:0]        p1_cmd;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ready;
  logic              p1_resp;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic              c_valid;
  logic [2:0]        c_cmd;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_resp;
  logic [DATA_W-1:0] c_rdata;

  // Environment side: requesters plus the cache adapter.
  modport master (
    output p0_valid, p0_cmd, p0_addr, p0_wdata,
    input  p0_ready, p0_resp, p0_rdata, p0_err,
    output p1_valid, p1_cmd, p1_addr, p1_wdata,
    input  p1_ready, p1_resp, p1_rdata, p1_err,
    input  c_valid, c_cmd, c_addr, c_wdata,
    output c_resp, c_rdata
  );

  // Arbiter side.
  modport slave (
    input  p0_valid, p0_cmd, p0_addr, p0_wdata,
    output p0_ready, p0_resp, p0_rdata, p0_err,
    input  p1_valid, p1_cmd, p1_addr, p1_wdata,
    output p1_ready, p1_resp, p1_rdata, p1_err,
    output c_valid, c_cmd, c_addr, c_wdata,
    input  c_resp, c_rdata
  );
endinterface

// File: rtl/cache_port_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select; a tie goes to the port that did not win last.
// Purely combinational so it can also sit on the bus-2 side between cache and DMA.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_onehot
);
  always_comb begin
    grant_onehot = 2'b00;
    if (valid == 2'b11) begin
      grant_onehot = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant_onehot = valid;
    end
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the cache's single CPU-side port between instruction fetch (port 0) and
// data (port 1): round-robin, one transaction in flight, timeout-to-error in WAIT.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  cache_port_arbiter_if.slave   bus,
  output arb_state_t            dbg_state
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state;
  logic              last_grant;
  logic              owner;
  c1_cmd_t           cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt;
  logic              c_valid_q;
  logic [1:0]        resp_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        grant;
  c1_cmd_t           sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_data;

  rr_arbiter2 u_rr (
    .valid        ({bus.p1_valid, bus.p0_valid}),
    .last_grant   (last_grant),
    .grant_onehot (grant)
  );

  assign sel_cmd   = grant[1] ? c1_cmd_t'(bus.p1_cmd) : c1_cmd_t'(bus.p0_cmd);
  assign sel_addr  = grant[1] ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant[1] ? bus.p1_wdata : bus.p0_wdata;

  // Ready is the accept strobe itself; held low in reset so no request is lost.
  assign bus.p0_ready = RESET_N && (state == S_IDLE) && grant[0];
  assign bus.p1_ready = RESET_N && (state == S_IDLE) && grant[1];

  assign bus.c_valid  = c_valid_q;
  assign bus.c_cmd    = cmd_q;
  assign bus.c_addr   = addr_q;
  assign bus.c_wdata  = wdata_q;
  assign bus.p0_resp  = resp_q[0];
  assign bus.p1_resp  = resp_q[1];
  assign bus.p0_err   = err_q[0];
  assign bus.p1_err   = err_q[1];
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
  assign dbg_state    = state;

  // Completion: an illegal command ends in ISSUE, a real one ends in WAIT on
  // c_resp (which wins over a coincident timeout) or on the last timeout cycle.
  always_comb begin
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    case (state)
      S_ISSUE: begin
        if (illegal_q) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.c_resp) begin
          fin      = 1'b1;
          fin_data = DATA_W'(mask_rdata(cmd_q, 32'(bus.c_rdata)));
        end else if (cnt == CNT_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_q      <= C1_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      illegal_q  <= 1'b0;
      cnt        <= '0;
      c_valid_q  <= 1'b0;
      resp_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      c_valid_q <= 1'b0;
      resp_q    <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;

      case (state)
        S_IDLE: begin
          if (|grant) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            cmd_q      <= sel_cmd;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            illegal_q  <= (sel_cmd == C1_NOP);
            // A NOP still spends one cycle in ISSUE, but never reaches the cache.
            c_valid_q  <= (sel_cmd != C1_NOP);
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= '0;
          if (!illegal_q) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!fin) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RETURN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (fin) begin
        state         <= S_RETURN;
        resp_q[owner] <= 1'b1;
        err_q[owner]  <= fin_err;
        if (owner) begin
          rdata1_q <= fin_data;
        end else begin
          rdata0_q <= fin_data;
        end
      end
    end
  end

endmodule
